// File: rtl/ibex_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_arb_pkg
// Description : Shared types and limits for the Ibex memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_arb_pkg;

   // Identifies which Ibex interface owns a transaction
   typedef enum logic {
      ArbPortInstr = 1'b0,
      ArbPortData  = 1'b1
   } arb_port_e;

   // Largest supported number of granted-but-unanswered transactions
   localparam int unsigned ArbMaxOutstandingLimit = 8;

endpackage
`default_nettype wire

// File: rtl/ibex_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ibex_arb_tag_fifo
// Description : In-order FIFO of transaction owners (one port ID per entry).
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_arb_tag_fifo
   import ibex_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  arb_port_e  wdata_i,
   input  logic       pop_i,
   output arb_port_e  rdata_o,
   output logic [3:0] count_o,
   output logic       empty_o,
   output logic       full_o
);

   localparam int unsigned      c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);

   arb_port_e          r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wptr;
   logic [c_ptr_w-1:0] r_rptr;
   logic [3:0]         r_count;
   logic               w_push;
   logic               w_pop;

   // Overflow and underflow requests are ignored so the count stays coherent
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   assign empty_o = (r_count == 4'd0);
   assign full_o  = (r_count == 4'(DEPTH));
   assign count_o = r_count;
   assign rdata_o = r_mem[r_rptr];

   // Entry storage, written on push only
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= wdata_i;
      end
   end

   // Pointers wrap at DEPTH; count moves only when push and pop differ
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= 4'd0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 4'd1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 4'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ibex_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ibex_mem_arbiter
// Description : 2:1 arbiter sharing one memory between Ibex fetch and LSU,
//               with in-order response routing, locking and round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_mem_arbiter
   import ibex_arb_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2,
   parameter bit          RoundRobin     = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic [6:0]  instr_rdata_intg_o,
   output logic        instr_err_o,

   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   input  logic [6:0]  data_wdata_intg_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic [6:0]  data_rdata_intg_o,
   output logic        data_err_o,

   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [6:0]  mem_wdata_intg_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic [6:0]  mem_rdata_intg_i,
   input  logic        mem_err_i,

   output logic [3:0]  outstanding_o,
   output logic        unexpected_rvalid_o
);

   arb_port_e  r_last;
   arb_port_e  r_lock_port;
   logic       r_lock;
   logic       r_unexp;

   arb_port_e  w_sel_port;
   logic       w_sel_valid;
   logic       w_instr_elig;
   logic       w_data_elig;
   logic       w_grant;
   logic       w_pop;
   arb_port_e  w_head;
   logic [3:0] w_count;
   logic       w_empty;
   logic       w_full;

   // A full FIFO blocks both ports; only registered occupancy is used, so
   // a same-cycle response never frees a slot combinationally
   assign w_instr_elig = instr_req_i & ~w_full;
   assign w_data_elig  = data_req_i & ~w_full;

   // Port selection: a pending lock wins, otherwise priority/round-robin
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_port  = ArbPortInstr;
      if (r_lock) begin
         w_sel_port  = r_lock_port;
         w_sel_valid = (r_lock_port == ArbPortData) ? w_data_elig : w_instr_elig;
      end else if (w_instr_elig && w_data_elig) begin
         w_sel_valid = 1'b1;
         if (RoundRobin) begin
            w_sel_port = (r_last == ArbPortInstr) ? ArbPortData : ArbPortInstr;
         end else begin
            w_sel_port = ArbPortData;
         end
      end else if (w_data_elig) begin
         w_sel_valid = 1'b1;
         w_sel_port  = ArbPortData;
      end else if (w_instr_elig) begin
         w_sel_valid = 1'b1;
         w_sel_port  = ArbPortInstr;
      end
   end

   // Request mux; fetches are always full-word reads
   always_comb begin
      mem_we_o         = 1'b0;
      mem_be_o         = 4'hF;
      mem_addr_o       = instr_addr_i;
      mem_wdata_o      = 32'h0;
      mem_wdata_intg_o = 7'h0;
      if (w_sel_port == ArbPortData) begin
         mem_we_o         = data_we_i;
         mem_be_o         = data_be_i;
         mem_addr_o       = data_addr_i;
         mem_wdata_o      = data_wdata_i;
         mem_wdata_intg_o = data_wdata_intg_i;
      end
   end

   assign mem_req_o   = w_sel_valid & ~rst_i;
   assign w_grant     = mem_req_o & mem_gnt_i;
   assign instr_gnt_o = w_grant & (w_sel_port == ArbPortInstr);
   assign data_gnt_o  = w_grant & (w_sel_port == ArbPortData);

   // Response demux: the FIFO head names the owner of this response
   assign w_pop              = mem_rvalid_i & ~w_empty & ~rst_i;
   assign instr_rvalid_o     = w_pop & (w_head == ArbPortInstr);
   assign data_rvalid_o      = w_pop & (w_head == ArbPortData);
   assign instr_rdata_o      = mem_rdata_i;
   assign data_rdata_o       = mem_rdata_i;
   assign instr_rdata_intg_o = mem_rdata_intg_i;
   assign data_rdata_intg_o  = mem_rdata_intg_i;
   assign instr_err_o        = mem_err_i;
   assign data_err_o         = mem_err_i;

   assign outstanding_o       = w_count;
   assign unexpected_rvalid_o = r_unexp;

   ibex_arb_tag_fifo #(
      .DEPTH (MaxOutstanding)
   ) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_grant),
      .wdata_i (w_sel_port),
      .pop_i   (w_pop),
      .rdata_o (w_head),
      .count_o (w_count),
      .empty_o (w_empty),
      .full_o  (w_full)
   );

   // Lock holds a stalled request stable; it drops on grant or when the
   // locked port withdraws (mem_req_o then falls low)
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lock      <= 1'b0;
         r_lock_port <= ArbPortInstr;
         r_last      <= ArbPortInstr;
         r_unexp     <= 1'b0;
      end else begin
         r_lock <= mem_req_o & ~mem_gnt_i;
         if (mem_req_o && !mem_gnt_i) begin
            r_lock_port <= w_sel_port;
         end
         if (w_grant) begin
            r_last <= w_sel_port;
         end
         if (mem_rvalid_i && w_empty) begin
            r_unexp <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ibex_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_mem_arbiter
// Description : Self-checking bench for ibex_mem_arbiter (directed table,
//               hand-written reset sequence, randomized model comparison).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_mem_arbiter;

   localparam int unsigned MAXO = 2;
   localparam bit          RR   = 1'b1;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_addr_i, instr_rdata_o;
   logic [6:0]  instr_rdata_intg_o;
   logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
   logic [6:0]  data_wdata_intg_i, data_rdata_intg_o;
   logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [6:0]  mem_wdata_intg_o, mem_rdata_intg_i;
   logic [3:0]  outstanding_o;
   logic        unexpected_rvalid_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ibex_mem_arbiter #(
      .MaxOutstanding (MAXO),
      .RoundRobin     (RR)
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst_i),
      .instr_req_i         (instr_req_i),
      .instr_addr_i        (instr_addr_i),
      .instr_gnt_o         (instr_gnt_o),
      .instr_rvalid_o      (instr_rvalid_o),
      .instr_rdata_o       (instr_rdata_o),
      .instr_rdata_intg_o  (instr_rdata_intg_o),
      .instr_err_o         (instr_err_o),
      .data_req_i          (data_req_i),
      .data_we_i           (data_we_i),
      .data_be_i           (data_be_i),
      .data_addr_i         (data_addr_i),
      .data_wdata_i        (data_wdata_i),
      .data_wdata_intg_i   (data_wdata_intg_i),
      .data_gnt_o          (data_gnt_o),
      .data_rvalid_o       (data_rvalid_o),
      .data_rdata_o        (data_rdata_o),
      .data_rdata_intg_o   (data_rdata_intg_o),
      .data_err_o          (data_err_o),
      .mem_req_o           (mem_req_o),
      .mem_we_o            (mem_we_o),
      .mem_be_o            (mem_be_o),
      .mem_addr_o          (mem_addr_o),
      .mem_wdata_o         (mem_wdata_o),
      .mem_wdata_intg_o    (mem_wdata_intg_o),
      .mem_gnt_i           (mem_gnt_i),
      .mem_rvalid_i        (mem_rvalid_i),
      .mem_rdata_i         (mem_rdata_i),
      .mem_rdata_intg_i    (mem_rdata_intg_i),
      .mem_err_i           (mem_err_i),
      .outstanding_o       (outstanding_o),
      .unexpected_rvalid_o (unexpected_rvalid_o)
   );

   typedef struct {
      bit          ir;  logic [31:0] ia;
      bit          dr;  logic [31:0] da;  bit dw;
      bit          mg;  bit mv;  logic [31:0] md;
      bit          emr; logic [31:0] ema; bit ewe; logic [3:0] ebe;
      bit          eig; bit edg; bit eirv; bit edrv;
      int          eout; bit eun;
   } vec_t;

   function automatic vec_t mk(bit ir, logic [31:0] ia, bit dr, logic [31:0] da, bit dw,
                               bit mg, bit mv, logic [31:0] md,
                               bit emr, logic [31:0] ema, bit ewe, logic [3:0] ebe,
                               bit eig, bit edg, bit eirv, bit edrv, int eout, bit eun);
      vec_t v;
      v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.dw = dw;
      v.mg = mg; v.mv = mv; v.md = md;
      v.emr = emr; v.ema = ema; v.ewe = ewe; v.ebe = ebe;
      v.eig = eig; v.edg = edg; v.eirv = eirv; v.edrv = edrv;
      v.eout = eout; v.eun = eun;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(bit r, bit ir, logic [31:0] ia, bit dr, logic [31:0] da, bit dw,
                        bit mg, bit mv, logic [31:0] md);
      rst_i             = r;
      instr_req_i       = ir;
      instr_addr_i      = ia;
      data_req_i        = dr;
      data_addr_i       = da;
      data_we_i         = dw;
      data_be_i         = 4'h3;
      data_wdata_i      = 32'h1234_5678;
      data_wdata_intg_i = 7'h2A;
      mem_gnt_i         = mg;
      mem_rvalid_i      = mv;
      mem_rdata_i       = md;
      mem_rdata_intg_i  = 7'h11;
      mem_err_i         = 1'b0;
   endtask

   // Reference model state: queue of response owners (0 = instr, 1 = data)
   int mq[$];
   int m_last;
   int m_lock;
   bit m_unexp;

   initial begin
      vec_t tv[$];
      // Directed table: MaxOutstanding = 2, RoundRobin = 1
      tv.push_back(mk(0,0,0,0,0, 0,0,0,       0,0,0,0,        0,0,0,0, 0,0));
      tv.push_back(mk(1,'h100,0,0,0, 1,0,0,   1,'h100,0,4'hF, 1,0,0,0, 0,0));
      tv.push_back(mk(0,0,0,0,0, 0,1,'h55,    0,0,0,0,        0,0,1,0, 1,0));
      tv.push_back(mk(0,0,0,0,0, 0,0,0,       0,0,0,0,        0,0,0,0, 0,0));
      tv.push_back(mk(1,'h200,1,'h300,1, 1,0,0, 1,'h300,1,4'h3, 0,1,0,0, 0,0));
      tv.push_back(mk(1,'h200,1,'h300,0, 1,0,0, 1,'h200,0,4'hF, 1,0,0,0, 1,0));
      tv.push_back(mk(1,'h200,1,'h300,0, 1,1,'hA, 0,0,0,0,      0,0,0,1, 2,0));
      tv.push_back(mk(1,'h200,1,'h300,0, 1,1,'hB, 1,'h300,0,4'h3, 0,1,1,0, 1,0));
      tv.push_back(mk(0,0,0,0,0, 0,1,'hC,     0,0,0,0,        0,0,0,1, 1,0));
      tv.push_back(mk(0,0,0,0,0, 0,0,0,       0,0,0,0,        0,0,0,0, 0,0));
      tv.push_back(mk(0,0,1,'h400,0, 0,0,0,   1,'h400,0,4'h3, 0,0,0,0, 0,0));
      tv.push_back(mk(1,'h200,1,'h400,0, 0,0,0, 1,'h400,0,4'h3, 0,0,0,0, 0,0));
      tv.push_back(mk(1,'h200,1,'h400,0, 0,0,0, 1,'h400,0,4'h3, 0,0,0,0, 0,0));
      tv.push_back(mk(1,'h200,1,'h400,0, 1,0,0, 1,'h400,0,4'h3, 0,1,0,0, 0,0));
      tv.push_back(mk(1,'h200,1,'h400,0, 1,0,0, 1,'h200,0,4'hF, 1,0,0,0, 1,0));
      tv.push_back(mk(1,'h200,0,0,0, 1,1,'hD, 0,0,0,0,          0,0,0,1, 2,0));
      tv.push_back(mk(1,'h200,0,0,0, 1,0,0,   1,'h200,0,4'hF, 1,0,0,0, 1,0));
      tv.push_back(mk(0,0,0,0,0, 0,1,'hE,     0,0,0,0,        0,0,1,0, 2,0));
      tv.push_back(mk(0,0,0,0,0, 0,1,'hF,     0,0,0,0,        0,0,1,0, 1,0));
      tv.push_back(mk(0,0,0,0,0, 0,0,0,       0,0,0,0,        0,0,0,0, 0,0));
      tv.push_back(mk(0,0,0,0,0, 0,1,'h99,    0,0,0,0,        0,0,0,0, 0,0));
      tv.push_back(mk(0,0,0,0,0, 0,0,0,       0,0,0,0,        0,0,0,0, 0,1));
      tv.push_back(mk(0,0,0,0,0, 0,0,0,       0,0,0,0,        0,0,0,0, 0,1));

      drive(1, 0,0,0,0,0, 0,0,0);
      @(negedge clk);
      drive(1, 1,'h100,1,'h300,0, 1,1,0);
      #2;
      chk("rst mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst gnt", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
      chk("rst rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);

      foreach (tv[k]) begin
         @(negedge clk);
         drive(0, tv[k].ir, tv[k].ia, tv[k].dr, tv[k].da, tv[k].dw, tv[k].mg, tv[k].mv, tv[k].md);
         #2;
         chk($sformatf("v%0d mem_req", k), {31'd0, mem_req_o}, {31'd0, tv[k].emr});
         if (tv[k].emr) begin
            chk($sformatf("v%0d mem_addr", k), mem_addr_o, tv[k].ema);
            chk($sformatf("v%0d mem_we", k), {31'd0, mem_we_o}, {31'd0, tv[k].ewe});
            chk($sformatf("v%0d mem_be", k), {28'd0, mem_be_o}, {28'd0, tv[k].ebe});
         end
         chk($sformatf("v%0d instr_gnt", k), {31'd0, instr_gnt_o}, {31'd0, tv[k].eig});
         chk($sformatf("v%0d data_gnt", k), {31'd0, data_gnt_o}, {31'd0, tv[k].edg});
         chk($sformatf("v%0d instr_rvalid", k), {31'd0, instr_rvalid_o}, {31'd0, tv[k].eirv});
         chk($sformatf("v%0d data_rvalid", k), {31'd0, data_rvalid_o}, {31'd0, tv[k].edrv});
         if (tv[k].eirv) chk($sformatf("v%0d instr_rdata", k), instr_rdata_o, tv[k].md);
         if (tv[k].edrv) chk($sformatf("v%0d data_rdata", k), data_rdata_o, tv[k].md);
         chk($sformatf("v%0d outstanding", k), {28'd0, outstanding_o}, 32'(tv[k].eout));
         chk($sformatf("v%0d unexpected", k), {31'd0, unexpected_rvalid_o}, {31'd0, tv[k].eun});
      end

      // Reset with two transactions in flight, then a stale response
      @(negedge clk); drive(1, 0,0,0,0,0, 0,0,0);
      @(negedge clk); drive(0, 1,'h500,0,0,0, 1,0,0);
      @(negedge clk); drive(0, 1,'h504,0,0,0, 1,0,0);
      @(negedge clk); drive(1, 1,'h508,1,'h600,0, 1,1,'h77);
      #2;
      chk("midrst mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("midrst gnt", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
      chk("midrst rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
      chk("midrst outstanding before", {28'd0, outstanding_o}, 32'd2);
      @(negedge clk); drive(0, 0,0,0,0,0, 0,0,0);
      #2;
      chk("midrst outstanding after", {28'd0, outstanding_o}, 32'd0);
      chk("midrst unexpected clear", {31'd0, unexpected_rvalid_o}, 32'd0);
      @(negedge clk); drive(0, 0,0,0,0,0, 0,1,'h88);
      #2;
      chk("stale rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
      @(negedge clk); drive(0, 0,0,0,0,0, 0,0,0);
      #2;
      chk("stale unexpected", {31'd0, unexpected_rvalid_o}, 32'd1);

      // Randomized run against the queue-based reference model
      @(negedge clk); drive(1, 0,0,0,0,0, 0,0,0);
      mq.delete(); m_last = 0; m_lock = -1; m_unexp = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit r, ir, dr, mg, mv, full, ei, ed;
         int sel, owner;
         logic [31:0] e_addr, e_wdata;
         logic [3:0]  e_be;
         logic [6:0]  e_intg;
         bit          e_we;
         @(negedge clk);
         r  = ($urandom_range(0, 199) == 0);
         ir = ($urandom_range(0, 9) < 6);
         dr = ($urandom_range(0, 9) < 6);
         mg = ($urandom_range(0, 9) < 7);
         mv = (mq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) == 0);
         rst_i             = r;
         instr_req_i       = ir;
         instr_addr_i      = $urandom;
         data_req_i        = dr;
         data_addr_i       = $urandom;
         data_we_i         = $urandom_range(0, 1);
         data_be_i         = 4'($urandom);
         data_wdata_i      = $urandom;
         data_wdata_intg_i = 7'($urandom);
         mem_gnt_i         = mg;
         mem_rvalid_i      = mv;
         mem_rdata_i       = $urandom;
         mem_rdata_intg_i  = 7'($urandom);
         mem_err_i         = $urandom_range(0, 1);

         sel = -1;
         if (!r) begin
            full = (mq.size() >= MAXO);
            ei = ir && !full;
            ed = dr && !full;
            if (m_lock == 1) sel = ed ? 1 : -1;
            else if (m_lock == 0) sel = ei ? 0 : -1;
            else if (ei && ed) sel = RR ? 1 - m_last : 1;
            else if (ed) sel = 1;
            else if (ei) sel = 0;
         end
         owner = (!r && mv && mq.size() > 0) ? mq[0] : -1;
         if (sel == 1) begin
            e_addr = data_addr_i; e_we = data_we_i; e_be = data_be_i;
            e_wdata = data_wdata_i; e_intg = data_wdata_intg_i;
         end else begin
            e_addr = instr_addr_i; e_we = 1'b0; e_be = 4'hF;
            e_wdata = 32'h0; e_intg = 7'h0;
         end

         #2;
         chk("rnd mem_req", {31'd0, mem_req_o}, {31'd0, sel >= 0});
         if (sel >= 0) begin
            chk("rnd mem_addr", mem_addr_o, e_addr);
            chk("rnd mem_ctl", {mem_we_o, mem_be_o, mem_wdata_intg_o}, {20'd0, e_we, e_be, e_intg});
            chk("rnd mem_wdata", mem_wdata_o, e_wdata);
         end
         chk("rnd instr_gnt", {31'd0, instr_gnt_o}, {31'd0, sel == 0 && mg});
         chk("rnd data_gnt", {31'd0, data_gnt_o}, {31'd0, sel == 1 && mg});
         chk("rnd instr_rvalid", {31'd0, instr_rvalid_o}, {31'd0, owner == 0});
         chk("rnd data_rvalid", {31'd0, data_rvalid_o}, {31'd0, owner == 1});
         if (owner == 0) chk("rnd instr_resp", {instr_err_o, instr_rdata_intg_o, instr_rdata_o[23:0]},
                             {mem_err_i, mem_rdata_intg_i, mem_rdata_i[23:0]});
         if (owner == 1) chk("rnd data_resp", {data_err_o, data_rdata_intg_o, data_rdata_o[23:0]},
                             {mem_err_i, mem_rdata_intg_i, mem_rdata_i[23:0]});
         chk("rnd outstanding", {28'd0, outstanding_o}, 32'(mq.size()));
         chk("rnd unexpected", {31'd0, unexpected_rvalid_o}, {31'd0, m_unexp});

         if (r) begin
            mq.delete(); m_last = 0; m_lock = -1; m_unexp = 1'b0;
         end else begin
            if (owner >= 0) void'(mq.pop_front());
            else if (mv) m_unexp = 1'b1;
            if (sel >= 0 && mg) begin
               mq.push_back(sel);
               m_last = sel;
            end
            m_lock = (sel >= 0 && !mg) ? sel : -1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
